matrix_keypad_scan: RTL and testbench

- Drives the column strobes of a 4-row x 3-column membrane keypad and reads its rows back.
- Debounces at frame level and emits a 4-bit key code with a one-cycle valid pulse per accepted press.
- It is the input-side counterpart of the multiplexed seven-segment driver: it strobes time-multiplexed lines outward and samples the response.
- Output encoding equals the 12-button parallel keypad path (codes 1..12, 0 = none), so it drops in ahead of turn logic unchanged.

---
 rtl/keypad_pkg.sv | 8 +
 rtl/key_debounce.sv | 42 ++++
 rtl/matrix_keypad_scan.sv | 71 +++++++
 tb/tb_matrix_keypad_scan.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared keypad geometry and key-code constants
package keypad_pkg;
  localparam int N_ROW = 4;
  localparam int N_COL = 3;
  localparam int KEY_W = 4;
  localparam logic [KEY_W-1:0] KEY_NONE  = 4'd0;
  localparam logic [KEY_W-1:0] KEY_MULTI = 4'hF;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: frame-level stability filter with commit and valid-pulse generation
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] cand,
  input  logic             frame_end,
  output logic [KEY_W-1:0] scan_out,
  output logic             valid,
  output logic             key_held
);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  logic [SW-1:0]    stab, stab_nx;
  logic [KEY_W-1:0] prev, state;
  logic             commit;
  always_comb begin
    stab_nx = cand != prev ? SW'(1) : stab == SW'(DEBOUNCE_SCANS) ? stab : stab + SW'(1);
    commit  = frame_end && stab_nx == SW'(DEBOUNCE_SCANS) && cand != state && cand != KEY_MULTI;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab     <= '0;
      prev     <= KEY_NONE;
      state    <= KEY_NONE;
      scan_out <= KEY_NONE;
      valid    <= 1'b0;
    end else begin
      valid <= commit && cand != KEY_NONE;
      if (frame_end) begin
        stab <= stab_nx;
        prev <= cand;
      end
      if (commit) state <= cand;
      if (commit && cand != KEY_NONE) scan_out <= cand;
    end
  end
  // MULTI never reaches state, so any non-NONE state is a single key
  assign key_held = state != KEY_NONE;
endmodule

// File: rtl/matrix_keypad_scan.sv
// matrix_keypad_scan: 4x3 keypad column scanner with per-frame candidate and debounce
module matrix_keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [2:0]       col_out,
  input  logic [N_ROW-1:0] row_in,
  output logic [KEY_W-1:0] scan_out,
  output logic             valid,
  output logic             key_held
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0]    cnt;
  logic [1:0]       col;
  logic [N_ROW-1:0] r1, r2;
  logic [1:0]       acc_n, slot_n, tot_n;
  logic [KEY_W-1:0] acc_key, slot_key, tot_key, cand;
  logic [2:0]       sum;
  logic             last, frame_end;
  assign last      = cnt == CW'(SCAN_DIV - 1);
  assign frame_end = last && col == 2'd2;
  assign col_out   = ~(3'b001 << col);
  // key count saturates at 2: anything beyond one key is MULTI
  always_comb begin
    slot_n   = 2'd0;
    slot_key = KEY_NONE;
    for (int r = 0; r < N_ROW; r++)
      if (!r2[r]) begin
        slot_n   = slot_n == 2'd2 ? 2'd2 : slot_n + 2'd1;
        slot_key = KEY_W'(r * N_COL + int'(col) + 1);
      end
    sum     = {1'b0, acc_n} + {1'b0, slot_n};
    tot_n   = sum >= 3'd2 ? 2'd2 : sum[1:0];
    tot_key = slot_n != 2'd0 ? slot_key : acc_key;
    cand    = tot_n == 2'd0 ? KEY_NONE : tot_n == 2'd1 ? tot_key : KEY_MULTI;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      col     <= 2'd0;
      r1      <= '1;
      r2      <= '1;
      acc_n   <= 2'd0;
      acc_key <= KEY_NONE;
    end else begin
      r1 <= row_in;
      r2 <= r1;
      if (last) begin
        cnt     <= '0;
        col     <= col == 2'd2 ? 2'd0 : col + 2'd1;
        acc_n   <= frame_end ? 2'd0 : tot_n;
        acc_key <= frame_end ? KEY_NONE : tot_key;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
  key_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_deb (
    .clk      (clk),
    .rst      (rst),
    .cand     (cand),
    .frame_end(frame_end),
    .scan_out (scan_out),
    .valid    (valid),
    .key_held (key_held)
  );
endmodule

// File: tb/tb_matrix_keypad_scan.sv
// tb_matrix_keypad_scan: keypad emulation, frame-level reference model and valid-pulse scoreboard
module tb_matrix_keypad_scan;
  localparam int SD = 4;
  localparam int DS = 3;
  localparam int FR = 3 * SD;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  col_out;
  logic [3:0]  row_in, scan_out;
  logic        valid, key_held;
  logic [11:0] pressed = '0;
  int          cyc;
  int          errors = 0;
  int          checks = 0;
  logic [3:0]  eq_code[$];
  int          eq_cyc[$];
  logic [3:0]  hist[$];
  logic [3:0]  m_state = 4'd0;
  logic [3:0]  m_scan = 4'd0;
  int          fr = 0;

  always #5 clk = ~clk;

  matrix_keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk     (clk),
    .rst     (rst),
    .col_out (col_out),
    .row_in  (row_in),
    .scan_out(scan_out),
    .valid   (valid),
    .key_held(key_held)
  );

  // membrane matrix: a pressed key pulls its row low while its column is strobed
  always_comb begin
    row_in = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk)
    if (!rst) begin
      chk("col_out", int'(col_out), 7 ^ (1 << ((cyc / SD) % 3)));
      if (valid) begin
        if (eq_code.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got scan_out=%0d expected no pulse (cycle %0d)", scan_out, cyc);
        end else begin
          chk("valid_code", int'(scan_out), int'(eq_code.pop_front()));
          chk("valid_cycle", cyc, eq_cyc.pop_front());
        end
      end
    end

  function automatic logic [11:0] kb(input int k);
    logic [11:0] one = 12'd1;
    return one << (k - 1);
  endfunction

  function automatic logic [3:0] cand_of(input logic [11:0] p);
    int n = $countones(p);
    if (n == 0) return 4'd0;
    if (n > 1) return 4'hF;
    for (int i = 0; i < 12; i++) if (p[i]) return 4'(i + 1);
    return 4'd0;
  endfunction

  // one aligned frame: expectations are queued before the frame runs
  task automatic frame(input logic [11:0] p);
    logic [3:0] c;
    bit stable;
    pressed = p;
    c = cand_of(p);
    hist.push_back(c);
    stable = hist.size() >= DS;
    if (stable)
      for (int i = hist.size() - DS; i < hist.size(); i++) if (hist[i] != c) stable = 0;
    if (stable && c != 4'hF && c != m_state) begin
      m_state = c;
      if (c != 4'd0) begin
        m_scan = c;
        eq_code.push_back(c);
        eq_cyc.push_back(FR * (fr + 1));
      end
    end
    fr++;
    repeat (FR) @(negedge clk);
    chk("key_held", int'(key_held), int'(m_state != 4'd0));
    chk("scan_out", int'(scan_out), int'(m_scan));
  endtask

  task automatic partial(input logic [11:0] p, input int n);
    pressed = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_col_out", int'(col_out), 6);
    chk("rst_scan_out", int'(scan_out), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_key_held", int'(key_held), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hist.delete();
    eq_code.delete();
    eq_cyc.delete();
    m_state = 4'd0;
    m_scan = 4'd0;
    fr = 0;
  endtask

  initial begin
    logic [11:0] p;
    @(negedge clk);
    do_reset();
    partial(kb(4), 6);
    @(posedge clk);
    #2;
    do_reset();
    repeat (2) frame('0);
    repeat (6) frame(kb(6));
    repeat (3) frame('0);
    do_reset();
    frame(kb(6)); frame('0); frame(kb(6));
    repeat (4) frame('0);
    repeat (5) frame(kb(1) | kb(5));
    repeat (2) frame('0);
    repeat (4) frame(kb(3));
    repeat (4) frame(kb(9));
    repeat (3) frame('0);
    repeat (2) frame(kb(12));
    partial(kb(12), 5);
    do_reset();
    repeat (5) frame(kb(12));
    repeat (3) frame('0);
    repeat (14) begin
      case ($urandom_range(0, 2))
        0: p = '0;
        1: p = kb($urandom_range(1, 12));
        default: p = kb($urandom_range(1, 12)) | kb($urandom_range(1, 12));
      endcase
      repeat ($urandom_range(1, 5)) frame(p);
    end
    repeat (3) frame('0);
    chk("pending_pulses", eq_code.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
